pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Parametrised program-counter and next-PC generator for the single-cycle/pipelined RV32 core. It replaces the fixed 10-bit word-stepped counter with the following:
- configurable PC width and step
- a fetch-side valid/ready handshake
- stall and trap-redirect inputs
- target-misalignment detection
- a small return-address stack (RAS) for call/return tracking

It sits between decode/execute (which supply control and operands) and the instruction memory address port.

Parameters:
PC_W, 32, PC register width in bits; all PC arithmetic is modulo 2^PC_W
STEP, 4, sequential increment (4 = byte-addressed RV32, 1 = word-addressed)
ALIGN, 4, required target alignment in address units (power of two, ≥1)
RESET_VEC, 0, PC value loaded on reset
OFF_W, 21, width of signed offset input
RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
fetch_ready  input  1  instruction memory accepts current pc
stall  input  1  hazard stall; hold pc
redirect_valid  input  1  trap/exception redirect request
redirect_pc  input  PC_W  redirect target
pc_sel  input  2  00 seq, 01 branch, 10 jal, 11 jalr
branch_taken  input  1  branch condition result (pc_sel=01 only)
offset  input  OFF_W  signed immediate, sign-extended to PC_W
rs1_val  input  PC_W  jalr base register
link_push  input  1  instruction writes link register (call)
link_pop  input  1  instruction reads link register as return
pc  output  PC_W  current PC
pc_valid  output  1  pc is a valid fetch address
pc_plus  output  PC_W  combinational pc+STEP (link value)
misalign  output  1  registered one-cycle pulse: rejected misaligned target
misalign_addr  output  PC_W  offending target, held until next misalign
ras_top  output  PC_W  top RAS entry; 0 when empty
ras_empty  output  1  RAS holds no entries
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries

Behaviour:
- Reset values (reset=0, async): pc=RESET_VEC, pc_valid=0, misalign=0, misalign_addr=0, ras_count=0, RAS pointer=0, ras_empty=1.
- pc_valid rises at the first rising edge after reset deasserts. It is otherwise 1, except for the single cycle after a misalign event, when it is 0.
- advance = pc_valid & fetch_ready & ~stall.
- Target by pc_sel:
  - seq: pc+STEP
  - branch: taken ? pc+sext(offset) : pc+STEP
  - jal: pc+sext(offset)
  - jalr: (rs1_val+sext(offset)) with bit0 cleared
- Misalignment is checked only for non-sequential targets actually taken: target mod ALIGN ≠ 0.
- Priority per edge:
  1. redirect_valid: pc←redirect_pc, pc_valid←1. Ignores stall, fetch_ready and alignment; no RAS change.
  2. ~advance: hold pc, RAS and misalign_addr; misalign←0.
  3. Misaligned target: pc holds; misalign←1 for one cycle; misalign_addr←target; pc_valid←0 for one cycle; no RAS change.
  4. Otherwise: pc←target, misalign←0.
- RAS updates only on a committed case-4 update with pc_sel ∈ {jal, jalr}:
  - push only: entry[ptr]←pc_plus; ptr←ptr+1 (wraps mod RAS_DEPTH); count←min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten.
  - pop only: if count>0, ptr←ptr−1 and count−1; if empty, the pop is ignored.
  - push+pop: top entry replaced with pc_plus, count unchanged; if empty, acts as push.
- link_push/link_pop are ignored for seq and branch.
- ras_top = entry[ptr−1] when count>0, else 0.
- Reset asserted mid-stall or mid-misalign returns all state to reset values immediately.

Test Plan:
1. Reset release, fetch_ready=1, pc_sel=00 for 3 cycles → pc_valid=1 after first edge; pc 0→4→8→12.
2. pc=0x100, pc_sel=01, offset=−8: with branch_taken=1 → pc=0xF8; with branch_taken=0 → pc=0x104. With stall=1 the same stimulus → pc holds 0x100.
3. pc=0x200, pc_sel=10, offset=0x40, link_push=1 → pc=0x240, ras_top=0x204, ras_count=1. Then pc_sel=11, rs1_val=0x204, offset=0, link_pop=1 → pc=0x204, ras_empty=1.
4. pc_sel=11, rs1_val=0x302, offset=0 → pc holds; misalign pulses 1 for one cycle; misalign_addr=0x302; pc_valid=0 for one cycle; RAS unchanged.
5. Five pushes at pcs 0x0, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH=4 → ras_count=4, ras_top=0x44. Four pops return 0x44, 0x34, 0x24, 0x14; a fifth pop is ignored with count=0.
6. redirect_valid=1, redirect_pc=0x80, with stall=1 and fetch_ready=0 → pc=0x80 next edge. Asserting reset=0 mid-cycle → pc=RESET_VEC immediately.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program counter and next-PC generator: sequential/branch/jal/jalr target selection,
// trap redirect, misaligned-target rejection and a small return-address stack.
module pc_next_unit #(
  parameter int              PC_W      = 32,
  parameter int              STEP      = 4,
  parameter int              ALIGN     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              OFF_W     = 21,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_ready,
  input  logic                             stall,
  input  logic                             redirect_valid,
  input  logic [PC_W-1:0]                  redirect_pc,
  input  logic [1:0]                       pc_sel,
  input  logic                             branch_taken,
  input  logic [OFF_W-1:0]                 offset,
  input  logic [PC_W-1:0]                  rs1_val,
  input  logic                             link_push,
  input  logic                             link_pop,
  output logic [PC_W-1:0]                  pc,
  output logic                             pc_valid,
  output logic [PC_W-1:0]                  pc_plus,
  output logic                             misalign,
  output logic [PC_W-1:0]                  misalign_addr,
  output logic [PC_W-1:0]                  ras_top,
  output logic                             ras_empty,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

  localparam int              PTR_W      = $clog2(RAS_DEPTH);
  localparam int              CNT_W      = $clog2(RAS_DEPTH+1);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(ALIGN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JAL    = 2'b10,
    SEL_JALR   = 2'b11
  } pc_sel_e;

  // Handshake: pc is offered to fetch while pc_valid is high; it is consumed and the
  // counter moves on a rising edge where pc_valid && fetch_ready && !stall.
  logic              advance;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   jalr_sum;
  logic [PC_W-1:0]   target;
  logic              non_seq;
  logic              bad_target;
  logic              is_call_ret;
  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  top_idx;

  assign advance  = pc_valid & fetch_ready & ~stall;
  assign off_ext  = PC_W'($signed(offset));
  assign pc_plus  = pc + PC_W'(STEP);
  assign jalr_sum = rs1_val + off_ext;

  always_comb begin
    target  = pc_plus;
    non_seq = 1'b0;
    case (pc_sel_e'(pc_sel))
      SEL_BRANCH: begin
        if (branch_taken) begin
          target  = pc + off_ext;
          non_seq = 1'b1;
        end
      end
      SEL_JAL: begin
        target  = pc + off_ext;
        non_seq = 1'b1;
      end
      SEL_JALR: begin
        target  = {jalr_sum[PC_W-1:1], 1'b0};
        non_seq = 1'b1;
      end
      default: begin
        target  = pc_plus;
        non_seq = 1'b0;
      end
    endcase
  end

  assign bad_target  = non_seq && ((target & ALIGN_MASK) != '0);
  assign is_call_ret = pc_sel[1];
  assign top_idx     = ras_ptr - PTR_W'(1);
  assign ras_empty   = (ras_count == '0);
  assign ras_top     = ras_empty ? '0 : ras_mem[top_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_VEC;
      pc_valid      <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      ras_ptr       <= '0;
      ras_count     <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      pc_valid <= 1'b1;
      misalign <= 1'b0;
    end else if (!advance) begin
      pc_valid <= 1'b1;
      misalign <= 1'b0;
    end else if (bad_target) begin
      // Target rejected: pc holds and fetch is withdrawn for one cycle.
      misalign      <= 1'b1;
      misalign_addr <= target;
      pc_valid      <= 1'b0;
    end else begin
      pc       <= target;
      pc_valid <= 1'b1;
      misalign <= 1'b0;
      if (is_call_ret) begin
        if (link_push && (!link_pop || ras_empty)) begin
          // When full the write lands on the oldest slot, which the pointer wraps onto.
          ras_mem[ras_ptr] <= pc_plus;
          ras_ptr          <= ras_ptr + PTR_W'(1);
          if (ras_count != CNT_FULL) ras_count <= ras_count + CNT_W'(1);
        end else if (link_push && link_pop) begin
          ras_mem[top_idx] <= pc_plus;
        end else if (link_pop && !ras_empty) begin
          ras_ptr   <= top_idx;
          ras_count <= ras_count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the PC and return-address stack.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [20:0] offset;
  logic [31:0] rs1_val;
  logic        link_push;
  logic        link_pop;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_plus;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic [2:0]  ras_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_mis_addr;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] ras_q[$];

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_ready   (fetch_ready),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_sel        (pc_sel),
    .branch_taken  (branch_taken),
    .offset        (offset),
    .rs1_val       (rs1_val),
    .link_push     (link_push),
    .link_pop      (link_pop),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pc_plus       (pc_plus),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .ras_top       (ras_top),
    .ras_empty     (ras_empty),
    .ras_count     (ras_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_valid    = 1'b0;
    m_mis      = 1'b0;
    m_mis_addr = 32'h0;
    ras_q.delete();
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_top;
    exp_top = (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : 32'h0;
    check({tag, ".pc"},            pc,            m_pc);
    check({tag, ".pc_valid"},      pc_valid,      m_valid);
    check({tag, ".pc_plus"},       pc_plus,       m_pc + 32'd4);
    check({tag, ".misalign"},      misalign,      m_mis);
    check({tag, ".misalign_addr"}, misalign_addr, m_mis_addr);
    check({tag, ".ras_count"},     ras_count,     ras_q.size());
    check({tag, ".ras_empty"},     ras_empty,     ras_q.size() == 0);
    check({tag, ".ras_top"},       ras_top,       exp_top);
  endtask

  // Next state from the rules: priority redirect > hold > misaligned > update.
  task automatic model_step();
    int          o;
    logic [31:0] tgt;
    logic [31:0] lnk;
    bit          ns;
    o = $signed(offset);
    if (redirect_valid) begin
      m_pc    = redirect_pc;
      m_valid = 1'b1;
      m_mis   = 1'b0;
    end else if (!(m_valid && fetch_ready && !stall)) begin
      m_valid = 1'b1;
      m_mis   = 1'b0;
    end else begin
      ns  = 1'b1;
      tgt = m_pc + 32'd4;
      case (pc_sel)
        2'd0: ns = 1'b0;
        2'd1: if (branch_taken) tgt = m_pc + o; else ns = 1'b0;
        2'd2: tgt = m_pc + o;
        default: tgt = (rs1_val + o) & 32'hFFFF_FFFE;
      endcase
      if (ns && (tgt % 4 != 0)) begin
        m_mis      = 1'b1;
        m_mis_addr = tgt;
        m_valid    = 1'b0;
      end else begin
        lnk     = m_pc + 32'd4;
        m_pc    = tgt;
        m_mis   = 1'b0;
        m_valid = 1'b1;
        if (pc_sel >= 2'd2) begin
          if (link_push && link_pop && ras_q.size() > 0) begin
            ras_q[ras_q.size()-1] = lnk;
          end else if (link_push) begin
            if (ras_q.size() == 4) void'(ras_q.pop_front());
            ras_q.push_back(lnk);
          end else if (link_pop && ras_q.size() > 0) begin
            void'(ras_q.pop_back());
          end
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    fetch_ready    = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    pc_sel         = 2'd0;
    branch_taken   = 1'b0;
    offset         = 21'h0;
    rs1_val        = 32'h0;
    link_push      = 1'b0;
    link_pop       = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    idle();
    redirect_valid = 1'b1;
    redirect_pc    = addr;
    cycle("redir");
    idle();
  endtask

  initial begin
    int tmp;
    idle();
    reset = 1'b0;
    model_reset();
    #12;
    check("rst.pc", pc, 32'h0);
    check("rst.pc_valid", pc_valid, 1'b0);
    check("rst.ras_empty", ras_empty, 1'b1);
    check_all("rst");

    // Release and sequential stepping
    @(negedge clk);
    reset = 1'b1;
    cycle("first");
    check("first.valid", pc_valid, 1'b1);
    check("first.pc", pc, 32'h0);
    cycle("seq1"); check("seq1.pc", pc, 32'h4);
    cycle("seq2"); check("seq2.pc", pc, 32'h8);
    cycle("seq3"); check("seq3.pc", pc, 32'hC);

    // Branch taken under stall, then taken, then not taken
    redirect_to(32'h100);
    pc_sel = 2'd1; offset = 21'h1FFFF8; branch_taken = 1'b1; stall = 1'b1;
    cycle("br_stall"); check("br_stall.pc", pc, 32'h100);
    stall = 1'b0;
    cycle("br_taken"); check("br_taken.pc", pc, 32'hF8);
    redirect_to(32'h100);
    pc_sel = 2'd1; offset = 21'h1FFFF8; branch_taken = 1'b0;
    cycle("br_not"); check("br_not.pc", pc, 32'h104);

    // Call then return
    redirect_to(32'h200);
    pc_sel = 2'd2; offset = 21'h40; link_push = 1'b1;
    cycle("call");
    check("call.pc", pc, 32'h240);
    check("call.ras_top", ras_top, 32'h204);
    check("call.ras_count", ras_count, 3'd1);
    idle();
    pc_sel = 2'd3; rs1_val = 32'h204; link_pop = 1'b1;
    cycle("ret");
    check("ret.pc", pc, 32'h204);
    check("ret.ras_empty", ras_empty, 1'b1);

    // Misaligned jalr is rejected, RAS untouched even with push requested
    idle();
    pc_sel = 2'd3; rs1_val = 32'h302; link_push = 1'b1;
    cycle("mis");
    check("mis.pc", pc, 32'h204);
    check("mis.pulse", misalign, 1'b1);
    check("mis.addr", misalign_addr, 32'h302);
    check("mis.valid", pc_valid, 1'b0);
    check("mis.ras_count", ras_count, 3'd0);
    idle();
    cycle("mis_after");
    check("mis_after.pulse", misalign, 1'b0);
    check("mis_after.valid", pc_valid, 1'b1);
    check("mis_after.addr", misalign_addr, 32'h302);

    // RAS overflow and underflow
    for (int i = 0; i < 5; i++) begin
      redirect_to(32'(i * 16));
      pc_sel = 2'd2; offset = 21'h100; link_push = 1'b1;
      cycle("push");
    end
    check("full.count", ras_count, 3'd4);
    check("full.top", ras_top, 32'h44);
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) check("pop.top", ras_top, 32'h44 - 32'(i * 16));
      pc_sel = 2'd3; rs1_val = 32'h1000; link_pop = 1'b1;
      cycle("pop");
    end
    check("pop_empty.count", ras_count, 3'd0);
    check("pop_empty.empty", ras_empty, 1'b1);

    // Redirect overrides stall / not-ready, then async reset mid-cycle
    idle();
    pc_sel = 2'd2; offset = 21'h10; link_push = 1'b1;
    cycle("pre_redir");
    idle();
    stall = 1'b1; fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    cycle("redir_stall");
    check("redir_stall.pc", pc, 32'h80);
    idle();
    stall = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    check("async_rst.pc", pc, 32'h0);
    check("async_rst.valid", pc_valid, 1'b0);
    check("async_rst.count", ras_count, 3'd0);
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    idle();
    cycle("rerelease");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      stall          = ($urandom_range(4) == 0);
      fetch_ready    = ($urandom_range(4) != 0);
      pc_sel         = 2'($urandom_range(3));
      branch_taken   = 1'($urandom_range(1));
      tmp            = (int'($urandom_range(512)) - 256) * 4;
      offset         = ($urandom_range(7) == 0) ? 21'($urandom) : 21'(tmp);
      rs1_val        = $urandom & (($urandom_range(5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      link_push      = 1'($urandom_range(1));
      link_pop       = 1'($urandom_range(1));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
